// File: rtl/srlatch_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the SR-latch exerciser: FSM states, the
// seven-step command sequence and the per-step drive/expect record.
package srlatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         STEP_COUNT = 7;
    localparam logic [2:0] NO_FAIL    = 3'd7;

    // Step encodings, in the order the sequence runs them.
    localparam logic [2:0] STEP_INIT    = 3'd0;
    localparam logic [2:0] STEP_SET     = 3'd1;
    localparam logic [2:0] STEP_HOLD1   = 3'd2;
    localparam logic [2:0] STEP_RESET   = 3'd3;
    localparam logic [2:0] STEP_HOLD0   = 3'd4;
    localparam logic [2:0] STEP_ILLEGAL = 3'd5;
    localparam logic [2:0] STEP_RETURN  = 3'd6;
    localparam logic [2:0] LAST_STEP    = 3'(STEP_COUNT - 1);

    // What one step drives onto S/R and what a NOR latch should answer.
    typedef struct packed {
        logic s;
        logic r;
        logic exp_q;
        logic exp_qn;
        logic check_en;
    } step_entry_t;

endpackage

// File: rtl/srlatch_step_rom.sv
`timescale 1ns/1ps
// Combinational step table: step index -> {S, R, expected Q, expected Qn,
// check enable}. Init and return steps are driven but never checked; the
// return from S=R=1 to hold is a race in a real NOR latch.
module srlatch_step_rom
    import srlatch_pkg::*;
(
    input  logic [2:0]  step,
    output step_entry_t entry
);

    // Decode the step index into its drive and expectation record.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        entry = '0;
        case (step)
            STEP_INIT:    entry = '{s: 1'b0, r: 1'b0, exp_q: 1'b0, exp_qn: 1'b0, check_en: 1'b0};
            STEP_SET:     entry = '{s: 1'b1, r: 1'b0, exp_q: 1'b1, exp_qn: 1'b0, check_en: 1'b1};
            STEP_HOLD1:   entry = '{s: 1'b0, r: 1'b0, exp_q: 1'b1, exp_qn: 1'b0, check_en: 1'b1};
            STEP_RESET:   entry = '{s: 1'b0, r: 1'b1, exp_q: 1'b0, exp_qn: 1'b1, check_en: 1'b1};
            STEP_HOLD0:   entry = '{s: 1'b0, r: 1'b0, exp_q: 1'b0, exp_qn: 1'b1, check_en: 1'b1};
            STEP_ILLEGAL: entry = '{s: 1'b1, r: 1'b1, exp_q: 1'b0, exp_qn: 1'b0, check_en: 1'b1};
            STEP_RETURN:  entry = '{s: 1'b0, r: 1'b0, exp_q: 1'b0, exp_qn: 1'b0, check_en: 1'b0};
            default:      entry = '0;
        endcase
    end

endmodule

// File: rtl/srlatch_exerciser.sv
`timescale 1ns/1ps
// On-board exerciser for an SR latch: on start it walks the seven-step S/R
// sequence, holds each step SETTLE cycles, samples Q/Qn in a one-cycle CHECK
// and tallies mismatches against the ideal NOR-latch response.
module srlatch_exerciser
    import srlatch_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Q,
    input  logic       Qn,
    output logic       S,
    output logic       R,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [2:0] fail_step,
    output logic [2:0] step
);

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("srlatch_exerciser: SETTLE must be at least 1");
        end
    endgenerate

    localparam int             CNT_W    = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [2:0]        step_d, err_d, fail_d;
    logic              s_d, r_d;
    logic              mismatch;
    step_entry_t       cur_entry;
    step_entry_t       nxt_entry;

    // Expectation for the step being checked now.
    srlatch_step_rom u_check_rom (
        .step  (step),
        .entry (cur_entry)
    );

    // Drive values for the step the FSM is moving into, so S/R are registered
    // on the same edge that advances the step.
    srlatch_step_rom u_drive_rom (
        .step  (step_d),
        .entry (nxt_entry)
    );

    assign mismatch = cur_entry.check_en &&
                      ({Q, Qn} != {cur_entry.exp_q, cur_entry.exp_qn});

    // Next-state, settle counter, step advance and error bookkeeping.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        step_d  = step;
        err_d   = err_count;
        fail_d  = fail_step;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    step_d  = STEP_INIT;
                    err_d   = '0;
                    fail_d  = NO_FAIL;
                end
            end
            DRIVE: begin
                if (cnt == CNT_LAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_count + 3'd1;
                    if (fail_step == NO_FAIL) begin
                        fail_d = step;
                    end
                end
                if (step == LAST_STEP) begin
                    state_d = DONE;
                    step_d  = STEP_INIT;
                end else begin
                    state_d = DRIVE;
                    step_d  = step + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        s_d = ((state_d == DRIVE) || (state_d == CHECK)) ? nxt_entry.s : 1'b0;
        r_d = ((state_d == DRIVE) || (state_d == CHECK)) ? nxt_entry.r : 1'b0;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            step      <= STEP_INIT;
            err_count <= '0;
            fail_step <= NO_FAIL;
            S         <= 1'b0;
            R         <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            step      <= step_d;
            err_count <= err_d;
            fail_step <= fail_d;
            S         <= s_d;
            R         <= r_d;
        end
    end

    // Status flags decode straight from the registered state.
    always_comb begin
        busy = (state == DRIVE) || (state == CHECK);
        done = (state == DONE);
        pass = (state == DONE) && (err_count == 3'd0);
    end

endmodule

// File: tb/tb_srlatch_exerciser.sv
`timescale 1ns/1ps
// Self-checking bench: two exercisers (SETTLE=2 and SETTLE=1) each drive a
// behavioural NOR-latch model with optional stuck-at faults. Expected S/R per
// cycle are queued when start is issued and popped as the DUT runs.
module tb_srlatch_exerciser;

    logic clk = 1'b0;
    logic rst;
    logic start2, start1;
    logic q2, qn2, s2, r2, busy2, done2, pass2;
    logic q1, qn1, s1, r1, busy1, done1, pass1;
    logic [2:0] err2, fail2, step2, err1, fail1, step1;

    int tests = 0;
    int fails = 0;
    int fault = 0;   // 0 good latch, 1 Q stuck at 0, 2 Qn stuck at 1
    int sel   = 0;   // 0 observes the SETTLE=2 instance, 1 the SETTLE=1 one

    logic [1:0] sr_tab [7] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00};
    logic [1:0] sr_q [$];

    always #5 clk = ~clk;

    srlatch_exerciser #(.SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .Q(q2), .Qn(qn2),
        .S(s2), .R(r2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_step(fail2), .step(step2)
    );

    srlatch_exerciser #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .Q(q1), .Qn(qn1),
        .S(s1), .R(r1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_step(fail1), .step(step1)
    );

    // Behavioural NOR latches: held state plus immediate response to S/R.
    logic lq2 = 1'b0, lq1 = 1'b0;
    logic nq2, nq1;
    always @(posedge clk) begin
        if (s2 && !r2) lq2 <= 1'b1; else if (r2 && !s2) lq2 <= 1'b0;
        if (s1 && !r1) lq1 <= 1'b1; else if (r1 && !s1) lq1 <= 1'b0;
    end
    always_comb begin
        nq2 = (s2 && !r2) ? 1'b1 : ((r2 && !s2) ? 1'b0 : lq2);
        nq1 = (s1 && !r1) ? 1'b1 : ((r1 && !s1) ? 1'b0 : lq1);
        q2  = (fault == 1) ? 1'b0 : (nq2 & ~(s2 & r2));
        qn2 = (fault == 2) ? 1'b1 : (~nq2 & ~(s2 & r2));
        q1  = (fault == 1) ? 1'b0 : (nq1 & ~(s1 & r1));
        qn1 = (fault == 2) ? 1'b1 : (~nq1 & ~(s1 & r1));
    end

    logic o_s, o_r, o_busy, o_done, o_pass;
    logic [2:0] o_err, o_fail, o_step;
    always_comb begin
        o_s    = (sel == 1) ? s1    : s2;
        o_r    = (sel == 1) ? r1    : r2;
        o_busy = (sel == 1) ? busy1 : busy2;
        o_done = (sel == 1) ? done1 : done2;
        o_pass = (sel == 1) ? pass1 : pass2;
        o_err  = (sel == 1) ? err1  : err2;
        o_fail = (sel == 1) ? fail1 : fail2;
        o_step = (sel == 1) ? step1 : step2;
    end

    task automatic set_start(input logic v);
        if (sel == 1) start1 = v; else start2 = v;
    endtask

    // Compare every observable output against the reset/idle values.
    task automatic check_idle(input string name);
        tests++;
        if ({o_s, o_r, o_busy, o_done, o_pass, o_err, o_fail, o_step} !==
            {5'b00000, 3'd0, 3'd7, 3'd0}) begin
            fails++;
            $display("FAIL %s: S R busy done pass err fail step = %b %b %b %b %b %0d %0d %0d, want 0 0 0 0 0 0 7 0",
                     name, o_s, o_r, o_busy, o_done, o_pass, o_err, o_fail, o_step);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b1; start2 = 1'b1;   // start coincident with reset
        repeat (2) @(negedge clk);
        sel = 0; check_idle("reset_settle2");
        sel = 1; check_idle("reset_settle1");
        start1 = 1'b0; start2 = 1'b0; rst = 1'b0;
        @(negedge clk);
        sel = 0; check_idle("idle_after_reset");
    endtask

    // One full sequence on the selected instance, checked cycle by cycle.
    task automatic test_run(input int which, input int fault_mode,
                            input logic [2:0] exp_err, input logic [2:0] exp_fail,
                            input bit mid_start, input string name);
        int settle;
        int len;
        logic [1:0] exp_sr;
        logic [2:0] exp_step;
        logic exp_pass;
        sel    = which;
        fault  = fault_mode;
        settle = (which == 1) ? 1 : 2;
        len    = 7 * (settle + 1);
        sr_q.delete();
        for (int st = 0; st < 7; st++)
            for (int c = 0; c <= settle; c++)
                sr_q.push_back(sr_tab[st]);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int n = 1; n <= len; n++) begin
            if (n > 1) @(negedge clk);
            exp_sr   = sr_q.pop_front();
            exp_step = 3'((n - 1) / (settle + 1));
            tests++;
            if ({o_s, o_r, o_busy, o_done, o_step} !== {exp_sr, 2'b10, exp_step}) begin
                fails++;
                $display("FAIL %s cycle %0d: S R busy done step = %b %b %b %b %0d, want %b %b 1 0 %0d",
                         name, n, o_s, o_r, o_busy, o_done, o_step,
                         exp_sr[1], exp_sr[0], exp_step);
            end
            if (n == 1) begin
                tests++;
                if ({o_err, o_fail} !== {3'd0, 3'd7}) begin
                    fails++;
                    $display("FAIL %s clear_on_start: err fail = %0d %0d, want 0 7",
                             name, o_err, o_fail);
                end
            end
            if (mid_start && n == 5) set_start(1'b1);
            if (mid_start && n == 6) set_start(1'b0);
        end
        @(negedge clk);
        exp_pass = (exp_err == 3'd0);
        tests++;
        if ({o_s, o_r, o_busy, o_done, o_pass, o_err, o_fail} !==
            {4'b0001, exp_pass, exp_err, exp_fail}) begin
            fails++;
            $display("FAIL %s end: S R busy done pass err fail = %b %b %b %b %b %0d %0d, want 0 0 0 1 %b %0d %0d",
                     name, o_s, o_r, o_busy, o_done, o_pass, o_err, o_fail,
                     exp_pass, exp_err, exp_fail);
        end
        @(negedge clk);
        tests++;
        if ({o_busy, o_done} !== 2'b01) begin
            fails++;
            $display("FAIL %s done_holds: busy done = %b %b, want 0 1", name, o_busy, o_done);
        end
    endtask

    // Reset at cycle 8 of a run with a Q-stuck latch: one error is already
    // counted and must be discarded.
    task automatic test_mid_reset();
        sel   = 0;
        fault = 1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (7) @(negedge clk);
        tests++;
        if ({o_busy, o_err} !== {1'b1, 3'd1}) begin
            fails++;
            $display("FAIL mid_reset_before: busy err = %b %0d, want 1 1", o_busy, o_err);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_reset_after");
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_reset_stays_idle");
        fault = 0;
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        test_reset();
        test_run(0, 0, 3'd0, 3'd7, 1'b0, "clean_settle2");
        test_run(0, 1, 3'd2, 3'd1, 1'b0, "q_stuck0");
        test_run(0, 0, 3'd0, 3'd7, 1'b1, "restart_from_done_mid_start");
        test_run(0, 2, 3'd3, 3'd1, 1'b0, "qn_stuck1");
        test_mid_reset();
        test_run(1, 0, 3'd0, 3'd7, 1'b0, "clean_settle1");
        test_run(1, 1, 3'd2, 3'd1, 1'b0, "q_stuck0_settle1");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
